logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one combinational logic unit (operands a, b, 3-bit sel, 32-bit out) between two requesters.
- Each requester issues an operation through a valid/ready request channel and receives the result through a valid/ready response channel.
- Requests are granted round-robin and run one at a time.
- The block sits between the register-file/issue side and the logic unit, and drives the unit's a, b and sel inputs directly.

Parameters:
- WIDTH, 32, operand and result width.
- LU_LAT, 1, cycles from operand registers updating to sampling lu_out. Must be at least 1; 0 is illegal.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_sel  in  3  port 0 logic-unit select.
- req0_a  in  WIDTH  port 0 operand a.
- req0_b  in  WIDTH  port 0 operand b.
- req1_valid, req1_ready, req1_sel, req1_a, req1_b  same as port 0, for port 1.
- rsp0_valid  out  1  result valid for port 0.
- rsp0_ready  in  1  port 0 takes the result.
- rsp1_valid  out  1  result valid for port 1.
- rsp1_ready  in  1  port 1 takes the result.
- rsp_data  out  WIDTH  result bus shared by both ports.
- lu_a  out  WIDTH  to logic unit a.
- lu_b  out  WIDTH  to logic unit b.
- lu_sel  out  3  to logic unit sel.
- lu_out  in  WIDTH  from logic unit out.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  number of completed operations.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - All outputs are 0: lu_a, lu_b, lu_sel, rsp_data, op_count, busy, every ready and every valid.
  - last_grant resets to 1, so port 0 wins the first tie.
- Asserting rst_n mid-operation aborts the operation immediately. No response is produced for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection: if exactly one reqN_valid is high, that port wins. If both are high, the port not equal to last_grant wins.
  - reqN_ready is combinational and high only in IDLE, only for the winner. It is never high for both ports.
  - On the clock edge where the winner's valid and ready are both high:
    - sel, a and b are registered into lu_sel, lu_a and lu_b.
    - grant_id is set to the winning port.
    - The down-counter is loaded with LU_LAT-1.
    - The state moves to EXEC.
  - A requester may drop valid before it is granted; no operation is started.
  - When no request is accepted, lu_* keep their previous values.
- EXEC:
  - lu_* are held constant.
  - While the counter is non-zero, it decrements each cycle.
  - On the edge where counter==0, rsp_data captures lu_out and the state moves to RESP.
  - The result is therefore captured LU_LAT edges after the accept edge.
- RESP:
  - rsp{grant_id}_valid is high; the other rsp valid is low.
  - rsp_data is held stable until the response handshake.
  - On the edge where rsp{grant_id}_ready is high:
    - last_grant is set to grant_id.
    - op_count increments; it wraps from all-ones to 0.
    - The state moves to IDLE.
  - If the response ready is already high on entry, the handshake completes on the next edge.
- Request/response interaction:
  - No new request is accepted before the cycle after the response handshake. Minimum spacing between accepts is LU_LAT+2 cycles.
  - A request that is pending while a response is outstanding waits. If the other port is also pending, it is arbitrated against it in IDLE.
- busy is registered, high in EXEC and RESP.
- Ordering: a port never receives a response before its own request has been accepted. Responses complete in grant order.

Test Plan:
- Logic-unit stub for all scenarios: the bench models the logic unit as lu_out = lu_a ^ lu_b. LU_LAT=1 unless stated.
- Reset: hold rst_n=0, drive req0_valid=1 -> req0_ready=0, all outputs 0, busy=0. Release rst_n -> req0_ready=1 in the same cycle.
- Single op: req0_sel=3'b010, a=32'hFFFF, b=32'h00F0 -> accepted at edge t. lu_sel=010, lu_a=FFFF, lu_b=00F0 after t. rsp0_valid=1, rsp_data=32'hFF0F after edge t+1. With rsp0_ready=1, rsp0_valid=0 after t+2 and op_count=1.
- Tie and round-robin: req0_valid=1 and req1_valid=1 held continuously, responses always ready -> grants alternate 0,1,0,1 with accepts 3 cycles apart. After 4 ops, op_count=4.
- Response back-pressure: hold rsp1_ready=0 for 5 cycles in RESP -> rsp1_valid and rsp_data stable, req0_ready=0 throughout. Release -> handshake, then port 0 granted in the next cycle.
- LU_LAT=3: accept at edge t -> rsp valid after edge t+3. lu_* unchanged during t..t+3, even if req payloads change.
- Async reset during EXEC: rst_n low mid-cycle -> busy, rsp_* and lu_* go to 0 immediately, no rsp_valid appears. Afterwards op_count=0 and port 0 wins the first tie. Separately, op_count preset near wrap (CNT_W=4, 16 ops) -> reads 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// logic_unit_arbiter: round-robin sharing of one combinational logic unit between two
// valid/ready requesters, one operation in flight at a time. Rev 1.0
module logic_unit_arbiter #(
  parameter int WIDTH  = 32,
  parameter int LU_LAT = 1,   // edges from operand update to lu_out sample; must be >= 1
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [2:0]       lu_sel,
  input  logic [WIDTH-1:0] lu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int             LAT_W    = (LU_LAT > 1) ? $clog2(LU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic             winner;
  logic             accept;
  logic             rsp_hs;
  logic [LAT_W-1:0] lat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    winner     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes next.
        winner     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        // Gated by rst_n so no ready is offered while reset is held.
        req0_ready = rst_n && req0_valid && !winner;
        req1_ready = rst_n && req1_valid && winner;
        accept     = req0_ready || req1_ready;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        if (lat_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = !grant_id;
        rsp1_valid = grant_id;
        rsp_hs     = grant_id ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_a       <= '0;
      lu_b       <= '0;
      lu_sel     <= '0;
      rsp_data   <= '0;
      op_count   <= '0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (accept) begin
        lu_sel   <= winner ? req1_sel : req0_sel;
        lu_a     <= winner ? req1_a   : req0_a;
        lu_b     <= winner ? req1_b   : req0_b;
        grant_id <= winner;
        lat_cnt  <= LAT_LOAD;
      end
      if (state == EXEC) begin
        if (lat_cnt == '0) rsp_data <= lu_out;
        else               lat_cnt  <= lat_cnt - 1'b1;
      end
      if (rsp_hs) begin
        last_grant <= grant_id;
        op_count   <= op_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// tb_logic_unit_arbiter: directed bench; three instances (LU_LAT=1, LU_LAT=3, CNT_W=4)
// share one set of inputs, each with a stub logic unit lu_out = lu_a ^ lu_b.
module tb_logic_unit_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [2:0]  req0_sel, req1_sel;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid, m_busy;
  logic [31:0] m_rsp_data, m_lu_a, m_lu_b, m_lu_out;
  logic [2:0]  m_lu_sel;
  logic [15:0] m_op_count;

  logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_busy;
  logic [31:0] s_rsp_data, s_lu_a, s_lu_b, s_lu_out;
  logic [2:0]  s_lu_sel;
  logic [15:0] s_op_count;

  logic        w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_busy;
  logic [31:0] w_rsp_data, w_lu_a, w_lu_b, w_lu_out;
  logic [2:0]  w_lu_sel;
  logic [3:0]  w_op_count;

  int errors = 0;
  int checks = 0;

  assign m_lu_out = m_lu_a ^ m_lu_b;
  assign s_lu_out = s_lu_a ^ s_lu_b;
  assign w_lu_out = w_lu_a ^ w_lu_b;

  logic_unit_arbiter #(.WIDTH(32), .LU_LAT(1), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(m_req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(m_req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(m_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(m_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(m_rsp_data), .lu_a(m_lu_a), .lu_b(m_lu_b), .lu_sel(m_lu_sel), .lu_out(m_lu_out),
    .busy(m_busy), .op_count(m_op_count)
  );

  logic_unit_arbiter #(.WIDTH(32), .LU_LAT(3), .CNT_W(16)) u_slow (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(s_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(s_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(s_rsp_data), .lu_a(s_lu_a), .lu_b(s_lu_b), .lu_sel(s_lu_sel), .lu_out(s_lu_out),
    .busy(s_busy), .op_count(s_op_count)
  );

  logic_unit_arbiter #(.WIDTH(32), .LU_LAT(1), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(w_rsp_data), .lu_a(w_lu_a), .lu_b(w_lu_b), .lu_sel(w_lu_sel), .lu_out(w_lu_out),
    .busy(w_busy), .op_count(w_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_sel = 3'b010; req0_a = 32'h0000FFFF; req0_b = 32'h000000F0; req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if ({m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid, m_busy} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid, m_busy}); end
    checks++; if ({m_lu_sel, m_lu_a, m_lu_b, m_rsp_data, m_op_count} !== '0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", {m_lu_sel, m_lu_a, m_lu_b, m_rsp_data, m_op_count}); end
    rst_n = 1'b1;
    #1;
    checks++; if ({m_req0_ready, m_req1_ready} !== 2'b10) begin errors++;
      $display("FAIL release_ready: got %b expected 10", {m_req0_ready, m_req1_ready}); end
    req0_valid = 1'b0;
    tick();
    checks++; if (m_busy !== 1'b0) begin errors++;
      $display("FAIL drop_before_grant: busy got %b expected 0", m_busy); end
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    #1;
    checks++; if ({m_req0_ready, m_req1_ready} !== 2'b10) begin errors++;
      $display("FAIL single_ready: got %b expected 10", {m_req0_ready, m_req1_ready}); end
    tick();
    req0_valid = 1'b0;
    checks++; if ({m_lu_sel, m_lu_a, m_lu_b} !== {3'b010, 32'h0000FFFF, 32'h000000F0}) begin errors++;
      $display("FAIL single_operands: got %h/%h/%h expected 2/0000ffff/000000f0", m_lu_sel, m_lu_a, m_lu_b); end
    checks++; if ({m_busy, m_rsp0_valid, m_rsp1_valid} !== 3'b100) begin errors++;
      $display("FAIL single_exec: got %b expected 100", {m_busy, m_rsp0_valid, m_rsp1_valid}); end
    tick();
    checks++; if ({m_rsp0_valid, m_rsp1_valid} !== 2'b10) begin errors++;
      $display("FAIL single_rsp_valid: got %b expected 10", {m_rsp0_valid, m_rsp1_valid}); end
    checks++; if (m_rsp_data !== 32'h0000FF0F) begin errors++;
      $display("FAIL single_rsp_data: got %h expected 0000ff0f", m_rsp_data); end
    tick();
    checks++; if ({m_rsp0_valid, m_busy, m_op_count} !== {2'b00, 16'd1}) begin errors++;
      $display("FAIL single_done: got valid=%b busy=%b count=%0d expected 0 0 1", m_rsp0_valid, m_busy, m_op_count); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_sel = 3'b001; req0_a = 32'h12345678; req0_b = 32'h0F0F0F0F;
    req1_sel = 3'b110; req1_a = 32'hA5A5A5A5; req1_b = 32'hFFFF0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_port;
      exp_port = k[0];
      #1;
      checks++; if ({m_req1_ready, m_req0_ready} !== {exp_port, ~exp_port}) begin errors++;
        $display("FAIL rr_ready[%0d]: got r1r0=%b%b expected port %0d", k, m_req1_ready, m_req0_ready, exp_port); end
      tick();
      tick();
      checks++; if ({m_rsp1_valid, m_rsp0_valid} !== {exp_port, ~exp_port}) begin errors++;
        $display("FAIL rr_rsp_valid[%0d]: got v1v0=%b%b expected port %0d", k, m_rsp1_valid, m_rsp0_valid, exp_port); end
      checks++; if (m_rsp_data !== (exp_port ? 32'h5A5AA5A5 : 32'h1D3B5977)) begin errors++;
        $display("FAIL rr_rsp_data[%0d]: got %h expected %h", k, m_rsp_data, (exp_port ? 32'h5A5AA5A5 : 32'h1D3B5977)); end
      tick();
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    checks++; if ({m_op_count, m_busy} !== {16'd4, 1'b0}) begin errors++;
      $display("FAIL rr_count: got count=%0d busy=%b expected 4 0", m_op_count, m_busy); end
  endtask

  task automatic test_backpressure();
    rsp1_ready = 1'b0;
    req1_valid = 1'b1;
    #1;
    checks++; if ({m_req1_ready, m_req0_ready} !== 2'b10) begin errors++;
      $display("FAIL bp_ready1: got r1r0=%b%b expected 10", m_req1_ready, m_req0_ready); end
    tick();
    req1_valid = 1'b0; req0_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if ({m_rsp1_valid, m_rsp0_valid, m_req0_ready} !== 3'b100) begin errors++;
        $display("FAIL bp_hold[%0d]: got v1 v0 r0=%b expected 100", k, {m_rsp1_valid, m_rsp0_valid, m_req0_ready}); end
      checks++; if (m_rsp_data !== 32'h5A5AA5A5) begin errors++;
        $display("FAIL bp_data[%0d]: got %h expected 5a5aa5a5", k, m_rsp_data); end
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    #1;
    checks++; if ({m_rsp1_valid, m_req0_ready, m_busy} !== 3'b010) begin errors++;
      $display("FAIL bp_release: got v1 r0 busy=%b expected 010", {m_rsp1_valid, m_req0_ready, m_busy}); end
    tick();
    req0_valid = 1'b0;
    checks++; if ({m_busy, m_lu_sel, m_lu_a} !== {1'b1, 3'b001, 32'h12345678}) begin errors++;
      $display("FAIL bp_next_grant: got busy=%b sel=%h a=%h expected 1 1 12345678", m_busy, m_lu_sel, m_lu_a); end
    tick();
    tick();
  endtask

  task automatic test_lat3();
    apply_reset();
    rsp0_ready = 1'b1;
    req0_sel = 3'b011; req0_a = 32'hF0F0F0F0; req0_b = 32'h0000FFFF; req0_valid = 1'b1;
    #1;
    checks++; if (s_req0_ready !== 1'b1) begin errors++;
      $display("FAIL lat3_ready: got %b expected 1", s_req0_ready); end
    tick();
    req0_sel = 3'b000; req0_a = 32'h0; req0_b = 32'h0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({s_lu_sel, s_lu_a, s_lu_b} !== {3'b011, 32'hF0F0F0F0, 32'h0000FFFF}) begin errors++;
        $display("FAIL lat3_operands[%0d]: got %h/%h/%h expected 3/f0f0f0f0/0000ffff", k, s_lu_sel, s_lu_a, s_lu_b); end
      checks++; if ({s_rsp0_valid, s_busy, s_req0_ready} !== 3'b010) begin errors++;
        $display("FAIL lat3_wait[%0d]: got valid busy ready=%b expected 010", k, {s_rsp0_valid, s_busy, s_req0_ready}); end
      tick();
    end
    checks++; if ({s_rsp0_valid, s_rsp_data} !== {1'b1, 32'hF0F00F0F}) begin errors++;
      $display("FAIL lat3_rsp: got valid=%b data=%h expected 1 f0f00f0f", s_rsp0_valid, s_rsp_data); end
    checks++; if (s_lu_a !== 32'hF0F0F0F0) begin errors++;
      $display("FAIL lat3_lu_hold: got %h expected f0f0f0f0", s_lu_a); end
    req0_valid = 1'b0;
    tick();
    checks++; if ({s_rsp0_valid, s_op_count} !== {1'b0, 16'd1}) begin errors++;
      $display("FAIL lat3_done: got valid=%b count=%0d expected 0 1", s_rsp0_valid, s_op_count); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_sel = 3'b100; req0_a = 32'h000000FF; req0_b = 32'h0;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    checks++; if (m_op_count !== 16'd1) begin errors++;
      $display("FAIL abort_pre_count: got %0d expected 1", m_op_count); end
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({m_busy, m_rsp0_valid, m_rsp1_valid} !== 3'b000) begin errors++;
      $display("FAIL abort_ctrl: got busy v0 v1=%b expected 000", {m_busy, m_rsp0_valid, m_rsp1_valid}); end
    checks++; if ({m_lu_sel, m_lu_a, m_lu_b, m_rsp_data} !== '0) begin errors++;
      $display("FAIL abort_data: got %h/%h/%h/%h expected 0", m_lu_sel, m_lu_a, m_lu_b, m_rsp_data); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if ({m_rsp0_valid, m_rsp1_valid, m_busy, m_op_count} !== '0) begin errors++;
        $display("FAIL abort_after[%0d]: got v0 v1 busy=%b count=%0d expected 0", k, {m_rsp0_valid, m_rsp1_valid, m_busy}, m_op_count); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({m_req1_ready, m_req0_ready} !== 2'b01) begin errors++;
      $display("FAIL abort_tie_port0: got r1r0=%b%b expected 01", m_req1_ready, m_req0_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        checks++; if (w_op_count !== 4'hF) begin errors++;
          $display("FAIL wrap_pre: got %h expected f", w_op_count); end
      end
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
    end
    checks++; if (w_op_count !== 4'h0) begin errors++;
      $display("FAIL wrap_zero: got %h expected 0", w_op_count); end
    checks++; if (m_op_count !== 16'd16) begin errors++;
      $display("FAIL wrap_wide: got %0d expected 16", m_op_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_sel = 3'b0; req0_a = 32'h0; req0_b = 32'h0;
    req1_sel = 3'b0; req1_a = 32'h0; req1_b = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lat3();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
